// File: rtl/mult33_pkg.sv
// Shared constants, scheduler state type and the round-robin search helper
// for the mult33 scheduler slice.
package mult33_pkg;

    localparam int OP_W    = 3;
    localparam int PROD_W  = 6;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        EMPTY,
        FULL
    } sched_state_t;

    // Returns {found, index}: first set bit of valid at or after ptr, wrapping mod num.
    function automatic logic [IDX_W:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        num
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        int unsigned      k;
        found = 1'b0;
        idx   = '0;
        for (int unsigned o = 0; o < num; o++) begin
            k = (32'(ptr) + o) % num;
            if (!found && valid[k[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = k[IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/comb_multi_33.sv
// Unsigned 3x3 combinational multiplier producing a 6-bit product.
module comb_multi_33 (
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic [5:0] p
);

    assign p = {3'b000, x} * {3'b000, y};

endmodule

// File: rtl/mult33_rr_arb.sv
// Combinational round-robin picker: one-hot grant and index of the first
// valid requester at or after ptr.
module mult33_rr_arb
    import mult33_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [IDX_W-1:0]   ptr_ext;
    logic [IDX_W:0]     pick;

    always_comb begin
        valid_ext              = '0;
        valid_ext[NUM_REQ-1:0] = valid;
        ptr_ext                = '0;
        ptr_ext[ID_W-1:0]      = ptr;
        pick                   = rr_pick(valid_ext, ptr_ext, NUM_REQ);
    end

    assign found = pick[IDX_W];
    assign idx   = pick[ID_W-1:0];

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant[i] = found && (pick[IDX_W-1:0] == i[IDX_W-1:0]);
        end
    end

endmodule

// File: rtl/mult33_rr_sched.sv
// Round-robin scheduler sharing one comb_multi_33 among NUM_REQ requesters.
// Define MULT33_RR_SCHED_STATS_EN to add per-requester saturating grant counters.
module mult33_rr_sched
    import mult33_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OP_W-1:0]   req_x,
    input  logic [NUM_REQ*OP_W-1:0]   req_y,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PROD_W-1:0]         out_p,
    output logic [ID_W-1:0]           out_id
`ifdef MULT33_RR_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*8-1:0]      grant_cnt
`endif
);

    sched_state_t        state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     win_idx;
    logic                found;
    logic                can_load;
    logic                handshake;
    logic [OP_W-1:0]     win_x, win_y;
    logic [PROD_W-1:0]   prod;

    mult33_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .found (found)
    );

    // The state register doubles as the result-valid flag.
    assign out_valid = (state == FULL);
    assign can_load  = (state == EMPTY) || out_ready;
    assign handshake = found && can_load && !rst;
    assign req_ready = grant & {NUM_REQ{can_load && !rst}};

    always_comb begin
        win_x = '0;
        win_y = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_x = req_x[OP_W*i +: OP_W];
                win_y = req_y[OP_W*i +: OP_W];
            end
        end
    end

    comb_multi_33 u_mult (
        .x (win_x),
        .y (win_y),
        .p (prod)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:   if (handshake) state_nxt = FULL;
            FULL:    if (out_ready) state_nxt = handshake ? FULL : EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_p  <= '0;
            out_id <= '0;
            rr_ptr <= '0;
        end else if (handshake) begin
            out_p  <= prod;
            out_id <= win_idx;
            rr_ptr <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
        end
    end

`ifdef MULT33_RR_SCHED_STATS_EN
    logic [7:0] cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (handshake && grant[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[8*i +: 8] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_mult33_rr_sched.sv
// Scoreboard bench for mult33_rr_sched: a behavioural predictor queues expected
// results, an independent monitor checks them as the DUT delivers.
module tb_mult33_rr_sched;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*3-1:0] req_x = '0;
    logic [N*3-1:0] req_y = '0;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [5:0]     out_p;
    logic [1:0]     out_id;
`ifdef MULT33_RR_SCHED_STATS_EN
    logic [N*8-1:0] grant_cnt;
    int             cnt_m [N];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int id;
        int p;
    } exp_t;
    exp_t sb[$];

    bit model_full = 1'b0;
    int model_ptr  = 0;

    always #5 clk = ~clk;

    mult33_rr_sched #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_id    (out_id)
`ifdef MULT33_RR_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Predictor: evaluates the scheduling rules on the inputs seen just before each edge.
    always @(negedge clk) begin
        int       w;
        bit       can_load;
        bit [N-1:0] exp_rdy;
        exp_t     e;
        if (rst) begin
            check("req_ready_in_reset", int'(req_ready), 0);
            sb.delete();
            model_full = 1'b0;
            model_ptr  = 0;
`ifdef MULT33_RR_SCHED_STATS_EN
            for (int j = 0; j < N; j++) cnt_m[j] = 0;
`endif
        end else begin
            check("out_valid", int'(out_valid), int'(model_full));
            can_load = !model_full || out_ready;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_valid[(model_ptr + k) % N]) w = (model_ptr + k) % N;
            end
            exp_rdy = '0;
            if (w >= 0 && can_load) exp_rdy[w] = 1'b1;
            check("req_ready", int'(req_ready), int'(exp_rdy));
            if (exp_rdy != '0) begin
                e.id = w;
                e.p  = int'(req_x[3*w +: 3]) * int'(req_y[3*w +: 3]);
                sb.push_back(e);
                model_ptr  = (w + 1) % N;
                model_full = 1'b1;
`ifdef MULT33_RR_SCHED_STATS_EN
                if (cnt_m[w] < 255) cnt_m[w]++;
`endif
            end else if (model_full && out_ready) begin
                model_full = 1'b0;
            end
        end
    end

    // Monitor: compares whatever the result register presents with the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL out_unexpected: out_valid=1 p=%0d id=%0d, expected no result", out_p, out_id);
            end else begin
                check("out_p", int'(out_p), sb[0].p);
                check("out_id", int'(out_id), sb[0].id);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] acc;

        // Reset with every requester asserting valid
        rst = 1'b1;
        req_valid = '1;
        req_x = 12'($urandom);
        req_y = 12'($urandom);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_p", int'(out_p), 0);
        check("reset_out_id", int'(out_id), 0);
        step();
        rst = 1'b0;
        req_valid = '0;
        step();

        // Single request from requester 2
        req_x[8:6] = 3'd7;
        req_y[8:6] = 3'd7;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (2) step();

        // Round robin from pointer 0, all requesters continuously valid
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_x[3*i +: 3] = 3'(i + 1);
            req_y[3*i +: 3] = 3'd3;
        end
        req_valid = '1;
        repeat (5) step();
        req_valid = '0;
        repeat (2) step();

        // Backpressure: 5*6 held while requester 1 waits
        req_x[2:0] = 3'd5;
        req_y[2:0] = 3'd6;
        req_valid = 4'b0001;
        step();
        req_x[5:3] = 3'd2;
        req_y[5:3] = 3'd3;
        req_valid = 4'b0010;
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        step();
        req_valid = '0;
        repeat (2) step();

        // Wrap and skip: pointer to 3 via requester 2, then only requester 1
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1111;
        step();
        req_valid = '0;
        repeat (2) step();

        // Exhaustive operand sweep on requester 0
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                req_x[2:0] = 3'(x);
                req_y[2:0] = 3'(y);
                req_valid = 4'b0001;
                step();
            end
        end
        req_valid = '0;
        repeat (2) step();

        // Randomised traffic obeying the hold-until-ready rule
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !acc[i]) begin
                    if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_x[3*i +: 3] = 3'($urandom);
                    req_y[3*i +: 3] = 3'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;

        // Drain
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) step();
        check("scoreboard_drained", sb.size(), 0);
`ifdef MULT33_RR_SCHED_STATS_EN
        for (int i = 0; i < N; i++) check("grant_cnt", int'(grant_cnt[8*i +: 8]), cnt_m[i]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult33_rr_sched.md
Name: mult33_rr_sched

Overview:
- Round-robin scheduler that shares one `comb_multi_33` 3x3 multiplier among NUM_REQ requesters.
- Each requester offers an (x,y) operand pair over valid/ready.
- The winner's operands go through the multiplier into a one-deep output register, tagged with the requester id.
- Sits between operand producers and a single result consumer; the result path is registered.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester id tag (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_x  in  NUM_REQ*3  packed multiplicands; requester i uses [3i+2:3i].
- req_y  in  NUM_REQ*3  packed multipliers; same packing as req_x.
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational.
- out_valid  out  1  result register holds a valid product.
- out_ready  in  1  consumer accepts the result.
- out_p  out  6  registered product x*y.
- out_id  out  ID_W  index of the requester that produced out_p.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_p=0, out_id=0.
  - Round-robin pointer rr_ptr=0.
  - FSM goes to EMPTY.
  - An in-flight result is discarded, not delivered.
  - While rst=1, req_ready is forced to 0.
- FSM states:
  - EMPTY: result register empty.
  - FULL: result register holds an undelivered product.
- Slot availability: can_load = (state==EMPTY) | (out_valid & out_ready).
- Arbitration (combinational):
  - Search begins at index rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins.
  - req_ready[winner] = can_load. All other req_ready bits are 0.
  - req_ready depends on req_valid and out_ready only, not on req_x/req_y.
- Transfer: a handshake occurs on requester i when req_valid[i] & req_ready[i]. At the next edge:
  - out_p <= req_x[i]*req_y[i], computed by `comb_multi_33`.
  - out_id <= i.
  - out_valid <= 1; state -> FULL.
  - rr_ptr <= (i+1) mod NUM_REQ.
- Latency: exactly 1 cycle from handshake to out_valid.
- Throughput: 1 result per cycle when out_ready is held high.
- FULL with out_ready=0:
  - out_p and out_id hold stable; out_valid stays 1.
  - All req_ready = 0.
- FULL with out_ready=1:
  - If a request is present, the new product loads in the same edge (back-to-back, no bubble).
  - Otherwise out_valid <= 0 and state -> EMPTY.
- No requests:
  - rr_ptr is unchanged.
  - out_p and out_id keep their last values while out_valid=0.
- Fairness: a requester holding valid high is served within NUM_REQ grants.
- Requester rules:
  - A requester must hold req_valid and its operands stable until ready.
  - Dropping valid before ready is allowed; the scheduler then skips that requester.
- Arithmetic: unsigned 3b x 3b -> 6b, never overflows (max 7*7=49).
- Reset mid-transfer: if rst and a handshake coincide, rst wins and the operand is not consumed (req_ready is 0).

Optional Feature:
- Macro: MULT33_RR_SCHED_STATS_EN.
- Defined:
  - Adds output grant_cnt, NUM_REQ*8 wide, packed like req_x.
  - One 8-bit saturating counter per requester, incremented on each handshake.
  - Each counter saturates at 255.
  - All counters reset to 0 on rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package mult33_pkg holds:
  - OP_W=3 and PROD_W=6 constants.
  - Enum sched_state_t {EMPTY, FULL}.
  - Function rr_pick(valid, ptr) returning the winner index and a found flag.
- Sub-module mult33_rr_arb: combinational round-robin picker, taking valid and ptr and producing a one-hot grant and an index.
- Top instantiates mult33_rr_arb and `comb_multi_33`.
- The top's operand mux feeds the multiplier from the winner's req_x/req_y.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all req_valid=1 -> out_valid=0, out_p=0, out_id=0, req_ready=0 throughout.
- Single request: req 2 offers x=7, y=7 with out_ready=1 -> req_ready=4'b0100 that cycle; next cycle out_valid=1, out_p=49, out_id=2.
- Round robin: all 4 requesters valid continuously (x=i+1, y=3), out_ready=1 -> out_id sequence 0,1,2,3,0.
  - out_p sequence 3,6,9,12,3.
  - out_valid stays 1 with no bubble.
- Backpressure: result x=5, y=6 pending with out_ready=0 for 3 cycles and req 1 valid -> out_p=30 held, req_ready=0.
  - When out_ready rises, req 1 (x=2, y=3) is accepted the same cycle and out_p=6 next cycle.
- Wrap and skip: rr_ptr=3 and only req 1 valid -> grant goes to req 1, then rr_ptr=2.
- Exhaustive: every x,y in 0..7 from requester 0 -> out_p == x*y for all 64 pairs.
